// File: rtl/riscv_arb_pkg.sv
// Shared types for the unified I/D memory arbiter.
package riscv_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  localparam int STREAK_W = 4;

endpackage

// File: rtl/riscv_arb_watchdog.sv
// Busy-cycle watchdog: counts cycles spent in a transaction and flags the
// cycle in which the transaction has lasted TIMEOUT_CYCLES cycles.
module riscv_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic active,
  output logic timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  // cnt holds the number of completed busy cycles; the current busy cycle
  // is the TIMEOUT_CYCLES-th one when cnt == TIMEOUT_CYCLES-1.
  assign timeout = active && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                 cnt <= '0;
    else if (start)             cnt <= '0;
    else if (active && !timeout) cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and the memory stage.
// Optional watchdog with sticky bus_error under RISCV_ARB_TIMEOUT_EN.
module riscv_mem_arbiter
  import riscv_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MEM_STREAK_MAX = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              bus_error
);

  state_t              state;
  logic [STREAK_W-1:0] streak;
  logic                if_elig, dm_elig;
  logic                grant_dm, grant_if;
  logic                wd_timeout;
  logic                finish;

  // A requester whose ack is out this cycle is finishing, not asking again.
  assign if_elig  = if_req && !if_ack;
  assign dm_elig  = dm_req && !dm_ack;
  assign grant_dm = dm_elig && !(if_elig && streak == STREAK_W'(MEM_STREAK_MAX));
  assign grant_if = if_elig && !grant_dm;
  assign busy     = (state != IDLE);
  assign finish   = busy && (mem_ack || wd_timeout);

`ifdef RISCV_ARB_TIMEOUT_EN
  riscv_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .start   (state == IDLE && (grant_dm || grant_if)),
    .active  (busy),
    .timeout (wd_timeout)
  );

  // A completion arriving in the timeout cycle is a normal completion.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                          bus_error <= 1'b0;
    else if (busy && wd_timeout && !mem_ack) bus_error <= 1'b1;
  end
`else
  assign wd_timeout = 1'b0;
  assign bus_error  = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      streak    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_dm) begin
            state     <= BUSY_DM;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            if (!if_elig)                                streak <= '0;
            else if (streak != STREAK_W'(MEM_STREAK_MAX)) streak <= streak + STREAK_W'(1);
          end else if (grant_if) begin
            state     <= BUSY_IF;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            streak    <= '0;
          end
        end
        BUSY_IF: begin
          if (finish) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            if_ack   <= 1'b1;
            if_rdata <= mem_ack ? mem_rdata : '0;
          end
        end
        BUSY_DM: begin
          if (finish) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            dm_ack   <= 1'b1;
            dm_rdata <= (mem_ack && !mem_we) ? mem_rdata : '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
